// File: rtl/aes_uart_pkg.sv
// Shared types and defaults for the AES harness UART receiver.
// Imported by the receiver top and its helpers.
package aes_uart_pkg;

  localparam int unsigned DEF_CLK_DIV   = 16;
  localparam int unsigned DEF_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  function automatic int unsigned cnt_w(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/aes_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// RST_VAL selects the value both flops take during reset.
module aes_sync2
  import aes_uart_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/aes_uart_rx.sv
// UART receiver: serial line to bytes with valid/ready output.
// LSB first, one start bit, DATA_BITS data bits, one stop bit.
module aes_uart_rx
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 io_clk,
  input  logic                 io_reset,
  input  logic                 io_rx,
  output logic                 io_valid,
  input  logic                 io_ready,
  output logic [DATA_BITS-1:0] io_payload,
  output logic                 io_frame_err,
  output logic                 io_overrun,
  output logic                 io_busy
);

  localparam int unsigned CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

  logic rxs;

  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic dlv_q, dlv_d;
  logic ferr_q, ferr_d;

  logic valid_q, valid_d;
  logic [DATA_BITS-1:0] payload_q, payload_d;
  logic ovr_q, ovr_d;
  logic fe_q, fe_d;
  logic pop;

  aes_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i(io_clk),
    .rst_i(io_reset),
    .d_i  (io_rx),
    .q_o  (rxs)
  );

  // Frame FSM, baud counter, bit index and shift register.
  always_ff @(posedge io_clk) begin
    if (io_reset) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      dlv_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dlv_q   <= dlv_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; the counter is cleared on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    dlv_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {rxs, sh_q[DATA_BITS-1:1]};
          if (bit_q == LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rxs) begin
            dlv_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = WAIT_IDLE;
      end
    endcase
  end

  // One-entry output buffer and the registered error pulses.
  always_ff @(posedge io_clk) begin
    if (io_reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
    end
  end

  // Delivery wins a slot if the buffer is empty or drains this cycle.
  always_comb begin
    pop       = valid_q & io_ready;
    valid_d   = valid_q & ~pop;
    payload_d = payload_q;
    ovr_d     = 1'b0;
    fe_d      = ferr_q;
    if (dlv_q) begin
      if (!valid_q || pop) begin
        payload_d = sh_q;
        valid_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign io_valid     = valid_q;
  assign io_payload   = payload_q;
  assign io_overrun   = ovr_q;
  assign io_frame_err = fe_q;
  assign io_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_uart_rx.sv
// Randomized bench for aes_uart_rx against a frame-level model.
// The model schedules each frame outcome at its arrival cycle.
module tb_aes_uart_rx;

  localparam int LAT = 155;
  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       valid;
  logic       ready;
  logic [7:0] payload;
  logic       ferr;
  logic       ovr;
  logic       busy;

  aes_uart_rx dut (
    .io_clk      (clk),
    .io_reset    (rst),
    .io_rx       (rx),
    .io_valid    (valid),
    .io_ready    (ready),
    .io_payload  (payload),
    .io_frame_err(ferr),
    .io_overrun  (ovr),
    .io_busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         bad;
    logic [7:0] data;
  } ev_t;

  ev_t evq[$];
  int  cyc = 0;
  int  nchk = 0;
  int  nerr = 0;
  bit  chk_en = 0;

  bit         mvalid = 0;
  logic [7:0] mdata = '0;
  bit         movr = 0;
  bit         mferr = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Reference: each frame resolves at t0+LAT into a byte or an error.
  always @(posedge clk) begin
    bit pop;
    bit nv;
    ev_t e;
    cyc++;
    if (rst) begin
      mvalid = 0;
      mdata  = '0;
      movr   = 0;
      mferr  = 0;
      evq.delete();
    end else begin
      pop   = mvalid && ready;
      nv    = mvalid && !pop;
      movr  = 0;
      mferr = 0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        if (e.bad) begin
          mferr = 1;
        end else if (!mvalid || pop) begin
          mdata = e.data;
          nv    = 1;
        end else begin
          movr = 1;
        end
      end
      mvalid = nv;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("valid", valid, mvalid);
      if (mvalid) check("payload", payload, mdata);
      check("overrun", ovr, movr);
      check("frame_err", ferr, mferr);
    end
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Call at #1 after an edge; the next edge samples the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    e.cyc  = cyc + 1 + LAT;
    e.bad  = !stop;
    e.data = b;
    evq.push_back(e);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop, BIT);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts;
    bit done;
    logic [7:0] b;
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_payload", payload, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    check("rst_busy", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1;
    hold(1'b1, 6);
    check("idle_busy", busy, 0);

    // clean frame with exact latency
    ready = 1'b1;
    ts = cyc + 1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_cyc(ts + LAT - 1);
        check("clean_early", valid, 0);
        wait_cyc(ts + LAT);
        check("clean_valid", valid, 1);
        check("clean_data", payload, 8'hA5);
        wait_cyc(ts + LAT + 1);
        check("clean_pulse", valid, 0);
      end
    join
    hold(1'b1, 10);

    // glitch shorter than half a bit
    ts = cyc + 1;
    hold(1'b0, 4);
    rx = 1'b1;
    wait_cyc(ts + 4);
    check("glitch_busy", busy, 1);
    wait_cyc(ts + 14);
    check("glitch_idle", busy, 0);
    hold(1'b1, 10);

    // framing error then recovery
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 40);
    check("ferr_busy", busy, 1);
    hold(1'b1, 4);
    check("ferr_idle", busy, 0);
    send_frame(8'h55, 1'b1);
    hold(1'b1, 10);

    // overrun: buffer full and not drained
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    ts = cyc + 1;
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_cyc(ts + LAT);
        check("ovr_pulse", ovr, 1);
        check("ovr_hold", payload, 8'h11);
      end
    join
    hold(1'b1, 5);
    check("ovr_keep", payload, 8'h11);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_popped", valid, 0);
    hold(1'b1, 5);

    // pop exactly on the delivery cycle
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    ts = cyc + 1;
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_cyc(ts + LAT - 1);
        check("sim_pre", payload, 8'h11);
        ready = 1'b1;
        wait_cyc(ts + LAT);
        ready = 1'b0;
        check("sim_valid", valid, 1);
        check("sim_data", payload, 8'h22);
        check("sim_novr", ovr, 0);
      end
    join
    ready = 1'b1;
    hold(1'b1, 5);

    // random frames under random back-pressure
    done = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          b = 8'($urandom);
          send_frame(b, ($urandom_range(0, 5) != 0));
          hold(1'b1, $urandom_range(2, 30));
        end
        done = 1;
      end
      begin
        while (!done) begin
          ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    ready = 1'b1;
    hold(1'b1, 5);

    // reset during data bit 3; the sender aborts too
    ready = 1'b0;
    send_frame(8'hC3, 1'b1);
    hold(1'b1, 5);
    b = 8'h77;
    hold(1'b0, BIT);
    for (int i = 0; i < 3; i++) hold(b[i], BIT);
    hold(b[3], BIT / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx  = 1'b1;
    check("mid_valid", valid, 0);
    check("mid_payload", payload, 0);
    check("mid_ferr", ferr, 0);
    check("mid_ovr", ovr, 0);
    check("mid_busy", busy, 1);
    hold(1'b1, 200);
    check("mid_novalid", valid, 0);
    ready = 1'b1;
    send_frame(8'h99, 1'b1);
    hold(1'b1, 10);
    check("q_empty", evq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
